// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester ram arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int REQ_IF      = 0;
  localparam int REQ_LS      = 1;
  localparam int DEF_ADR_W   = 16;
  localparam int DEF_DATA_W  = 64;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshakes plus the ram port, bundled for the arbiter.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADR_W  = DEF_ADR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req0, we0, lock0, ack0, rvalid0;
  logic [ADR_W-1:0]  adr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, lock1, ack1, rvalid1;
  logic [ADR_W-1:0]  adr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_writeData;
  logic              mem_writeEn;
  logic [DATA_W-1:0] mem_readData;

  modport slave (
    input  req0, we0, lock0, adr0, wdata0,
    input  req1, we1, lock1, adr1, wdata1,
    input  mem_readData,
    output ack0, rvalid0, rdata0,
    output ack1, rvalid1, rdata1,
    output mem_adr, mem_writeData, mem_writeEn
  );

  modport master (
    output req0, we0, lock0, adr0, wdata0,
    output req1, we1, lock1, adr1, wdata1,
    output mem_readData,
    input  ack0, rvalid0, rdata0,
    input  ack1, rvalid1, rdata1,
    input  mem_adr, mem_writeData, mem_writeEn
  );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational grant picker: round-robin when unowned, owner-only when locked.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       prio,
  input  arb_state_t state,
  output logic       gnt0,
  output logic       gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      LOCK0: gnt0 = req0;
      LOCK1: gnt1 = req1;
      default: begin
        if (!prio) begin
          gnt0 = req0;
          gnt1 = req1 & ~req0;
        end else begin
          gnt1 = req1;
          gnt0 = req0 & ~req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with bounded locking in front of a single-port ram;
// read data returns one cycle after the grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADR_W    = DEF_ADR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = 8
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam bit LOCK_EN = (LOCK_MAX > 1);

  arb_state_t        state, state_nxt;
  logic              prio, prio_nxt;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic              pick0, pick1, gnt0, gnt1;
  logic              own, own_req, own_lock;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;

  rr_pick2 u_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .prio  (prio),
    .state (state),
    .gnt0  (pick0),
    .gnt1  (pick1)
  );

  // Reset suppresses any grant so an access in flight is simply dropped.
  assign gnt0 = pick0 & ~rst;
  assign gnt1 = pick1 & ~rst;

  assign bus.ack0          = gnt0;
  assign bus.ack1          = gnt1;
  assign bus.mem_writeEn   = (gnt0 & bus.we0) | (gnt1 & bus.we1);
  assign bus.mem_adr       = gnt0 ? bus.adr0   : (gnt1 ? bus.adr1   : '0);
  assign bus.mem_writeData = gnt0 ? bus.wdata0 : (gnt1 ? bus.wdata1 : '0);
  assign bus.rvalid0       = rvalid0;
  assign bus.rvalid1       = rvalid1;
  assign bus.rdata0        = rdata0;
  assign bus.rdata1        = rdata1;

  assign own      = (state == LOCK1);
  assign own_req  = own ? bus.req1  : bus.req0;
  assign own_lock = own ? bus.lock1 : bus.lock0;

  always_comb begin
    state_nxt    = state;
    prio_nxt     = prio;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ARB: begin
        if (gnt0 | gnt1) begin
          if (LOCK_EN && ((gnt0 && bus.lock0) || (gnt1 && bus.lock1))) begin
            state_nxt    = gnt0 ? LOCK0 : LOCK1;
            lock_cnt_nxt = CNT_W'(1);
          end else begin
            prio_nxt = gnt0;
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!own_req || !own_lock || lock_cnt == CNT_LAST) begin
          state_nxt    = ARB;
          prio_nxt     = ~own;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      prio     <= 1'b0;
      lock_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      lock_cnt <= lock_cnt_nxt;
      rvalid0  <= gnt0 & ~bus.we0;
      rvalid1  <= gnt1 & ~bus.we1;
      if (gnt0 & ~bus.we0) rdata0 <= bus.mem_readData;
      if (gnt1 & ~bus.we1) rdata1 <= bus.mem_readData;
    end
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port 64-bit data ram (16-bit address, asynchronous read, write on rising clk). Requester 0 is the instruction-fetch side and requester 1 is the load/store side. Each cycle the block grants at most one requester, drives the ram port from the granted requester, and registers the read data back to that requester. Arbitration is round-robin. A requester can lock the ram for a bounded run of back-to-back accesses.

Parameters:
ADR_W, 16, ram address width
DATA_W, 64, ram data width
LOCK_MAX, 8, max consecutive grants one locked requester may take before forced release (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req0  in  1  requester 0 access request; held with command until ack0
we0  in  1  requester 0 write (1) / read (0)
lock0  in  1  requester 0 wants to keep ownership after this access
adr0  in  ADR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  access performed this cycle (combinational)
rvalid0  out  1  rdata0 valid (registered, one-cycle pulse)
rdata0  out  DATA_W  registered read data
req1, we1, lock1, adr1, wdata1, ack1, rvalid1, rdata1: same as above, requester 1
mem_adr  out  ADR_W  to ram adr
mem_writeData  out  DATA_W  to ram writeData
mem_writeEn  out  1  to ram writeEn
mem_readData  in  DATA_W  from ram readData

Behaviour:
- Reset (synchronous, active-high): state=ARB, prio=0, lock_cnt=0, rvalid0/1=0, rdata0/1=0. While rst=1, ack0/1=0 and mem_writeEn=0. Reset mid-access aborts it: no write, no rvalid.
- States:
  - ARB: no owner.
  - LOCK0: requester 0 owns the ram.
  - LOCK1: requester 1 owns the ram.
- Grant, combinational, gnt0/gnt1 one-hot or zero:
  - ARB: if req[prio], grant prio; else if req[other], grant other; else none.
  - LOCKi: grant i only if req_i. The other requester is never granted.
- ack_i = gnt_i.
- mem_adr / mem_writeData come from the granted requester. With no grant they are 0.
- mem_writeEn = gnt_i & we_i. The write commits at this clk edge.
- Read latency is 1: on the edge after a read grant, rdata_i <= mem_readData (sampled in the grant cycle) and rvalid_i <= 1. rvalid_i is 0 in every other cycle. rdata_i holds its value otherwise.
- Write-then-read of the same address by the two requesters in consecutive cycles returns the new data.
- On a grant to i in ARB:
  - If lock_i and LOCK_MAX>1: next state LOCKi, lock_cnt=1.
  - Otherwise: prio <= other.
- In LOCKi, on a grant:
  - If lock_i=0 or lock_cnt+1==LOCK_MAX: release to ARB, prio <= other, lock_cnt <= 0.
  - Otherwise: lock_cnt++.
- In LOCKi with req_i=0: release to ARB at the next edge, prio <= other, lock_cnt <= 0. No grant is issued that cycle.
- Guarantee: a continuously requesting loser is granted within LOCK_MAX+1 cycles.
- lock_cnt width: clog2(LOCK_MAX+1). It never wraps.
- A requester must not change we/adr/wdata while req=1 and ack=0. Dropping req before ack is legal and withdraws the request.

Decomposition:
- Shared package: state enum (ARB, LOCK0, LOCK1), requester-index constants (REQ_IF=0, REQ_LS=1), default widths ADR_W/DATA_W.
- One natural sub-module: rr_pick2. It is combinational and maps (req0, req1, prio, state) to the one-hot grant.
- The FSM, counter and read-return registers stay in ram_arbiter.

Test Plan:
- Reset then single read: preload mem[5]=0xAB; req0=1, we0=0, adr0=5 → ack0=1 that cycle; next cycle rvalid0=1, rdata0=0xAB; rvalid1 stays 0.
- Contention round-robin: req0 and req1 both held as reads of adr 1 and 2 for 4 cycles from reset → grants 0,1,0,1; rvalid alternates with rdata=mem[1], mem[2].
- Write then read across requesters: cycle n req1 writes 0x1234 to adr 7; cycle n+1 req0 reads adr 7 → rdata0=0x1234 at n+2.
- Lock bound: LOCK_MAX=3, lock0=1, req0 and req1 held → grants 0,0,0,1, then 0. Dropping lock0 after the 2nd grant releases immediately → next grant is to 1.
- Reset mid-operation: rst=1 in a cycle where req1 write is pending → mem_writeEn=0, memory unchanged; after reset, state=ARB, prio=0, rvalid=0.
- Idle: no req for 10 cycles → ack=0, mem_writeEn=0, mem_adr=0, state stays ARB, prio unchanged.
